// File: rtl/me_pkg.sv
// Shared constants and state encoding for the motion-estimation block scheduler.
package me_pkg;
    localparam int FILL_ROWS   = 8;
    localparam int SEARCH_COLS = 16;
    localparam int CORE_PHASES = 25;
    localparam int SAD_W       = 14;
    localparam int MV_W        = 4;
    localparam int PH_W        = 5;

    localparam logic [SAD_W-1:0] SAD_INIT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } me_state_e;
endpackage

// File: rtl/me_rd_addr_gen.sv
// Decodes the sequencing phase into frame-buffer read strobes and row addresses.
import me_pkg::*;

module me_rd_addr_gen #(
    parameter int ADDR_W = 12
) (
    input  logic              run,
    input  logic [PH_W-1:0]   ph,
    input  logic [ADDR_W-1:0] crt_base,
    input  logic [ADDR_W-1:0] pre_base,
    output logic              crt_rd_en,
    output logic [ADDR_W-1:0] crt_rd_addr,
    output logic              pre_rd_en,
    output logic [ADDR_W-1:0] pre_rd_addr
);
    localparam logic [PH_W-1:0] FILL_END   = PH_W'(FILL_ROWS);
    localparam logic [PH_W-1:0] SEARCH_END = PH_W'(FILL_ROWS + SEARCH_COLS);

    logic [PH_W-1:0] col;

    always_comb begin
        crt_rd_en   = 1'b0;
        crt_rd_addr = '0;
        pre_rd_en   = 1'b0;
        pre_rd_addr = '0;
        col         = ph - FILL_END;
        // Addresses are forced to zero outside their windows; sums wrap naturally.
        if (run && (ph < FILL_END)) begin
            crt_rd_en   = 1'b1;
            crt_rd_addr = crt_base + ADDR_W'(ph);
        end
        if (run && (ph >= FILL_END) && (ph < SEARCH_END)) begin
            pre_rd_en   = 1'b1;
            pre_rd_addr = pre_base + ADDR_W'(col);
        end
    end
endmodule

// File: rtl/me_block_scheduler.sv
// Sequences one 16x16 SAD search per job: row reads, core reset control, result capture.
import me_pkg::*;

module me_block_scheduler #(
    parameter int ADDR_W = 12,
    parameter int RD_LAT = 1,
    parameter int SAD_W  = 14,
    parameter int MV_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              job_valid,
    output logic              job_ready,
    input  logic [ADDR_W-1:0] job_crt_base,
    input  logic [ADDR_W-1:0] job_pre_base,
    output logic              crt_rd_en,
    output logic [ADDR_W-1:0] crt_rd_addr,
    output logic              pre_rd_en,
    output logic [ADDR_W-1:0] pre_rd_addr,
    output logic              core_rst,
    input  logic [SAD_W-1:0]  core_sad_min,
    input  logic [MV_W-1:0]   core_mv_x,
    input  logic [MV_W-1:0]   core_mv_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [SAD_W-1:0]  res_sad,
    output logic [MV_W-1:0]   res_mv_x,
    output logic [MV_W-1:0]   res_mv_y,
    output logic              busy
);
    localparam logic [PH_W-1:0] RD_PH = PH_W'(RD_LAT);
    localparam logic [PH_W-1:0] LAST  = PH_W'(CORE_PHASES - 1 + RD_LAT);

    me_state_e         state;
    logic [PH_W-1:0]   ph;
    logic [ADDR_W-1:0] crt_base;
    logic [ADDR_W-1:0] pre_base;

    assign job_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    // Core phase = ph - RD_LAT, so read data arrives in the phase that consumes it.
    assign core_rst  = !((state == RUN) && (ph >= RD_PH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ph        <= '0;
            crt_base  <= '0;
            pre_base  <= '0;
            res_valid <= 1'b0;
            res_sad   <= '1;
            res_mv_x  <= '0;
            res_mv_y  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (job_valid) begin
                        crt_base <= job_crt_base;
                        pre_base <= job_pre_base;
                        ph       <= '0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (ph == LAST) begin
                        res_sad   <= core_sad_min;
                        res_mv_x  <= core_mv_x;
                        res_mv_y  <= core_mv_y;
                        res_valid <= 1'b1;
                        ph        <= '0;
                        state     <= HOLD;
                    end else begin
                        ph <= ph + PH_W'(1);
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    me_rd_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_rd_addr_gen (
        .run         (state == RUN),
        .ph          (ph),
        .crt_base    (crt_base),
        .pre_base    (pre_base),
        .crt_rd_en   (crt_rd_en),
        .crt_rd_addr (crt_rd_addr),
        .pre_rd_en   (pre_rd_en),
        .pre_rd_addr (pre_rd_addr)
    );
endmodule
